// File: rtl/lcd_master_st_pkg.sv
// Shared types for the LCD master Avalon-ST adapters: header FSM states,
// default channel limit helper and the payload-beat layout.
package lcd_master_st_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } st_state_e;

  localparam int unsigned LCD_ST_DATA_W    = 8;
  localparam int unsigned LCD_ST_CHANNEL_W = 8;

  // Highest channel representable in w bits; w=32 wraps to all-ones.
  function automatic int unsigned default_max_channel(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  typedef struct packed {
    logic [LCD_ST_DATA_W-1:0]    data;
    logic                        sop;
    logic                        eop;
    logic [LCD_ST_CHANNEL_W-1:0] channel;
  } lcd_st_beat_t;

endpackage

// File: rtl/lcd_master_st_pipe_reg.sv
// One-entry ready/valid register. The caller only asserts load while in_ready
// is high; a take and a load on the same edge reload without a bubble.
module lcd_master_st_pipe_reg #(
  parameter type T = logic [7:0]
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  T     in_beat,
  output logic in_ready,
  input  logic out_ready,
  output logic out_valid,
  output T     out_beat
);

  logic valid_q, valid_d;
  T     beat_q, beat_d;

  always_comb begin
    in_ready = !valid_q || out_ready;
    valid_d  = valid_q && !out_ready;
    beat_d   = beat_q;
    if (load) begin
      valid_d = 1'b1;
      beat_d  = in_beat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      beat_q  <= '0;
    end else begin
      valid_q <= valid_d;
      beat_q  <= beat_d;
    end
  end

  assign out_valid = valid_q;
  assign out_beat  = beat_q;

endmodule

// File: rtl/lcd_master_chan_header_adapter.sv
// Strips the channel header beat from each packet and tags the payload with it;
// out-of-range packets are dropped and counted, framing errors pulse err_framing.
module lcd_master_chan_header_adapter
  import lcd_master_st_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned CHANNEL_W   = 8,
  parameter int unsigned MAX_CHANNEL = default_max_channel(CHANNEL_W),
  parameter int unsigned CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 in_ready,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    in_data,
  input  logic                 in_startofpacket,
  input  logic                 in_endofpacket,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_startofpacket,
  output logic                 out_endofpacket,
  output logic [CHANNEL_W-1:0] out_channel,
  output logic                 err_framing,
  output logic [CNT_W-1:0]     drop_count
);

  typedef struct packed {
    logic [DATA_W-1:0]    data;
    logic                 sop;
    logic                 eop;
    logic [CHANNEL_W-1:0] channel;
  } beat_t;

  // Clamp so a limit wider than the channel field simply means "never drop".
  localparam logic [CHANNEL_W-1:0] MAX_CH_L =
    (MAX_CHANNEL >= default_max_channel(CHANNEL_W)) ? {CHANNEL_W{1'b1}}
                                                     : CHANNEL_W'(MAX_CHANNEL);

  st_state_e            state_q, state_d;
  logic [CHANNEL_W-1:0] chan_q, chan_d;
  logic                 sop_pend_q, sop_pend_d;
  logic                 err_q, err_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CHANNEL_W-1:0] hdr_ch;
  logic                 pipe_ready, load, accept;
  beat_t                beat_in, beat_out;

  always_comb begin
    hdr_ch     = in_data[CHANNEL_W-1:0];
    in_ready   = (state_q == PASS) ? pipe_ready : 1'b1;
    accept     = in_valid && in_ready;
    state_d    = state_q;
    chan_d     = chan_q;
    sop_pend_d = sop_pend_q;
    err_d      = 1'b0;
    cnt_d      = cnt_q;
    load       = 1'b0;
    beat_in.data    = in_data;
    beat_in.sop     = sop_pend_q;
    beat_in.eop     = in_endofpacket;
    beat_in.channel = chan_q;

    if (accept) begin
      if (in_startofpacket) begin
        // A header outside IDLE abandons the current packet but is still honoured.
        err_d = (state_q != IDLE);
        if (in_endofpacket) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (hdr_ch > MAX_CH_L) begin
          state_d = DROP;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end else begin
          chan_d     = hdr_ch;
          sop_pend_d = 1'b1;
          state_d    = PASS;
        end
      end else begin
        unique case (state_q)
          IDLE: err_d = 1'b1;
          PASS: begin
            load       = 1'b1;
            sop_pend_d = 1'b0;
            if (in_endofpacket) state_d = IDLE;
          end
          DROP: if (in_endofpacket) state_d = IDLE;
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      chan_q     <= '0;
      sop_pend_q <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      chan_q     <= chan_d;
      sop_pend_q <= sop_pend_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  lcd_master_st_pipe_reg #(.T(beat_t)) u_pipe (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .in_beat   (beat_in),
    .in_ready  (pipe_ready),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_beat  (beat_out)
  );

  assign out_data          = beat_out.data;
  assign out_startofpacket = beat_out.sop;
  assign out_endofpacket   = beat_out.eop;
  assign out_channel       = beat_out.channel;
  assign err_framing       = err_q;
  assign drop_count        = cnt_q;

endmodule

// File: tb/tb_lcd_master_chan_header_adapter.sv
// Directed bench: default-parameter instance for pass/backpressure/framing/reset,
// MAX_CHANNEL=3 CNT_W=2 instance for drop and counter saturation.
module tb_lcd_master_chan_header_adapter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0, out_ready = 1'b1;
  logic [7:0] in_data = 8'h00;

  logic       ir0, ov0, os0, oe0, er0;
  logic [7:0] od0, oc0;
  logic [15:0] dc0;
  logic       ir1, ov1, os1, oe1, er1;
  logic [7:0] od1, oc1;
  logic [1:0] dc1;

  int checks = 0, failures = 0;
  int sel = 0;

  lcd_master_chan_header_adapter u_dut0 (
    .clk(clk), .reset(reset), .in_ready(ir0), .in_valid(in_valid), .in_data(in_data),
    .in_startofpacket(in_sop), .in_endofpacket(in_eop), .out_ready(out_ready),
    .out_valid(ov0), .out_data(od0), .out_startofpacket(os0), .out_endofpacket(oe0),
    .out_channel(oc0), .err_framing(er0), .drop_count(dc0)
  );

  lcd_master_chan_header_adapter #(.MAX_CHANNEL(3), .CNT_W(2)) u_dut1 (
    .clk(clk), .reset(reset), .in_ready(ir1), .in_valid(in_valid), .in_data(in_data),
    .in_startofpacket(in_sop), .in_endofpacket(in_eop), .out_ready(out_ready),
    .out_valid(ov1), .out_data(od1), .out_startofpacket(os1), .out_endofpacket(oe1),
    .out_channel(oc1), .err_framing(er1), .drop_count(dc1)
  );

  logic       m_ir, m_ov, m_os, m_oe, m_er;
  logic [7:0] m_od, m_oc;
  always_comb begin
    m_ir = sel ? ir1 : ir0;
    m_ov = sel ? ov1 : ov0;
    m_os = sel ? os1 : os0;
    m_oe = sel ? oe1 : oe0;
    m_er = sel ? er1 : er0;
    m_od = sel ? od1 : od0;
    m_oc = sel ? oc1 : oc0;
  end

  // Output beats taken downstream, logged away from the clock edge.
  logic [7:0] q_d[$], q_c[$];
  logic       q_s[$], q_e[$];
  int err_seen = 0, valid_seen = 0;
  always @(negedge clk) begin
    if (!reset) begin
      if (m_ov && out_ready) begin
        q_d.push_back(m_od); q_c.push_back(m_oc);
        q_s.push_back(m_os); q_e.push_back(m_oe);
      end
      if (m_ov) valid_seen++;
      if (m_er) err_seen++;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clear_log();
    q_d.delete(); q_c.delete(); q_s.delete(); q_e.delete();
    err_seen = 0; valid_seen = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = 8'h00;
    out_ready = 1'b1;
    step(); step();
    reset = 1'b0;
    clear_log();
  endtask

  // Holds the beat until the selected DUT accepts it; returns at posedge+1.
  task automatic send_beat(input logic [7:0] d, input logic s, input logic e);
    bit done = 0;
    in_valid = 1'b1; in_data = d; in_sop = s; in_eop = e;
    for (int t = 0; t < 20 && !done; t++) begin
      #1;
      if (m_ir) done = 1;
      step();
    end
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    if (!done) begin
      checks++; failures++;
      $display("FAIL send_timeout data=%0h in_ready never asserted", d);
    end
  endtask

  task automatic test_reset();
    sel = 0;
    do_reset();
    checks++;
    if ({ir0, ov0, od0, os0, oe0, oc0, er0} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=%b", {ir0, ov0, od0, os0, oe0, oc0, er0},
               {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0});
    end
    checks++;
    if ({dc0, dc1} !== 18'h0) begin
      failures++; $display("FAIL reset_drop_count got=%0h/%0h exp=0/0", dc0, dc1);
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp_d [3] = '{8'hA1, 8'hA2, 8'hA3};
    sel = 0;
    do_reset();
    send_beat(8'h05, 1'b1, 1'b0);
    send_beat(8'hA1, 1'b0, 1'b0);
    checks++;
    if ({ov0, od0, os0, oc0} !== {1'b1, 8'hA1, 1'b1, 8'h05}) begin
      failures++; $display("FAIL basic_latency got v=%b d=%0h s=%b c=%0h exp v=1 d=a1 s=1 c=5",
                           ov0, od0, os0, oc0);
    end
    send_beat(8'hA2, 1'b0, 1'b0);
    send_beat(8'hA3, 1'b0, 1'b1);
    repeat (3) step();
    checks++;
    if (q_d.size() != 3) begin
      failures++; $display("FAIL basic_count got=%0d exp=3", q_d.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if ({q_d[i], q_s[i], q_e[i], q_c[i]} !== {exp_d[i], i == 0, i == 2, 8'h05}) begin
          failures++; $display("FAIL basic_beat%0d got d=%0h s=%b e=%b c=%0h exp d=%0h c=5",
                               i, q_d[i], q_s[i], q_e[i], q_c[i], exp_d[i]);
        end
      end
    end
  endtask

  task automatic test_drop();
    logic [7:0] pk [5] = '{8'h07, 8'h11, 8'h12, 8'h13, 8'h14};
    sel = 1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = pk[i]; in_sop = (i == 0); in_eop = (i == 4);
      #1;
      checks++;
      if (ir1 !== 1'b1) begin
        failures++; $display("FAIL drop_in_ready beat%0d got=%b exp=1", i, ir1);
      end
      step();
    end
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    step();
    checks++;
    if (valid_seen != 0) begin
      failures++; $display("FAIL drop_out_valid got=%0d cycles exp=0", valid_seen);
    end
    checks++;
    if (dc1 !== 2'd1) begin
      failures++; $display("FAIL drop_count got=%0d exp=1", dc1);
    end
    send_beat(8'h02, 1'b1, 1'b0);
    send_beat(8'h31, 1'b0, 1'b0);
    send_beat(8'h32, 1'b0, 1'b1);
    repeat (3) step();
    checks++;
    if (q_d.size() != 2) begin
      failures++; $display("FAIL drop_follow_count got=%0d exp=2", q_d.size());
    end else begin
      checks++;
      if ({q_d[0], q_s[0], q_e[0], q_c[0], q_d[1], q_s[1], q_e[1], q_c[1]} !==
          {8'h31, 1'b1, 1'b0, 8'h02, 8'h32, 1'b0, 1'b1, 8'h02}) begin
        failures++; $display("FAIL drop_follow_beats got=%0h/%0h c=%0h/%0h exp=31/32 c=2/2",
                             q_d[0], q_d[1], q_c[0], q_c[1]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_d [4] = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
    sel = 0;
    do_reset();
    send_beat(8'h04, 1'b1, 1'b0);
    send_beat(8'hB1, 1'b0, 1'b0);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'hB2;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if ({ir0, ov0, od0} !== {1'b0, 1'b1, 8'hB1}) begin
        failures++; $display("FAIL bp_stall%0d got ready=%b v=%b d=%0h exp ready=0 v=1 d=b1",
                             c, ir0, ov0, od0);
      end
      step();
    end
    out_ready = 1'b1;
    send_beat(8'hB2, 1'b0, 1'b0);
    send_beat(8'hB3, 1'b0, 1'b0);
    send_beat(8'hB4, 1'b0, 1'b1);
    repeat (3) step();
    checks++;
    if (q_d.size() != 4) begin
      failures++; $display("FAIL bp_count got=%0d exp=4", q_d.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if ({q_d[i], q_s[i], q_e[i], q_c[i]} !== {exp_d[i], i == 0, i == 3, 8'h04}) begin
          failures++; $display("FAIL bp_beat%0d got d=%0h s=%b e=%b c=%0h exp d=%0h c=4",
                               i, q_d[i], q_s[i], q_e[i], q_c[i], exp_d[i]);
        end
      end
    end
  endtask

  task automatic test_framing();
    logic [7:0] exp_d [3] = '{8'hC1, 8'hC2, 8'hC3};
    logic [7:0] exp_c [3] = '{8'h01, 8'h06, 8'h06};
    logic       exp_s [3] = '{1'b1, 1'b1, 1'b0};
    logic       exp_e [3] = '{1'b0, 1'b0, 1'b1};
    sel = 0;
    do_reset();
    send_beat(8'hD0, 1'b0, 1'b0);
    checks++;
    if ({er0, ov0} !== 2'b10) begin
      failures++; $display("FAIL frame_nosop got err=%b v=%b exp err=1 v=0", er0, ov0);
    end
    step();
    checks++;
    if (er0 !== 1'b0) begin
      failures++; $display("FAIL frame_pulse_width got err=%b exp=0", er0);
    end
    send_beat(8'h02, 1'b1, 1'b1);
    checks++;
    if ({er0, ov0} !== 2'b10) begin
      failures++; $display("FAIL frame_empty_hdr got err=%b v=%b exp err=1 v=0", er0, ov0);
    end
    send_beat(8'h01, 1'b1, 1'b0);
    send_beat(8'hC1, 1'b0, 1'b0);
    send_beat(8'h06, 1'b1, 1'b0);
    checks++;
    if (er0 !== 1'b1) begin
      failures++; $display("FAIL frame_sop_in_pass got err=%b exp=1", er0);
    end
    send_beat(8'hC2, 1'b0, 1'b0);
    send_beat(8'hC3, 1'b0, 1'b1);
    repeat (3) step();
    checks++;
    if (err_seen != 3) begin
      failures++; $display("FAIL frame_err_total got=%0d exp=3", err_seen);
    end
    checks++;
    if (q_d.size() != 3) begin
      failures++; $display("FAIL frame_count got=%0d exp=3", q_d.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if ({q_d[i], q_s[i], q_e[i], q_c[i]} !== {exp_d[i], exp_s[i], exp_e[i], exp_c[i]}) begin
          failures++; $display("FAIL frame_beat%0d got d=%0h s=%b e=%b c=%0h exp d=%0h s=%b e=%b c=%0h",
                               i, q_d[i], q_s[i], q_e[i], q_c[i], exp_d[i], exp_s[i], exp_e[i], exp_c[i]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp;
    sel = 1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send_beat(8'h0F, 1'b1, 1'b0);
      send_beat(8'h55, 1'b0, 1'b1);
      exp = (i < 3) ? 2'(i + 1) : 2'd3;
      checks++;
      if (dc1 !== exp) begin
        failures++; $display("FAIL sat_count pkt%0d got=%0d exp=%0d", i, dc1, exp);
      end
    end
    checks++;
    if (valid_seen != 0) begin
      failures++; $display("FAIL sat_out_valid got=%0d cycles exp=0", valid_seen);
    end
  endtask

  task automatic test_reset_mid();
    sel = 0;
    do_reset();
    send_beat(8'h03, 1'b1, 1'b0);
    send_beat(8'h11, 1'b0, 1'b0);
    send_beat(8'h22, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    checks++;
    if ({ir0, ov0, od0, os0, oe0, oc0, er0} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      failures++;
      $display("FAIL rstmid_outputs got=%b exp=%b", {ir0, ov0, od0, os0, oe0, oc0, er0},
               {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0});
    end
    reset = 1'b0;
    clear_log();
    send_beat(8'h01, 1'b1, 1'b0);
    send_beat(8'h44, 1'b0, 1'b1);
    repeat (3) step();
    checks++;
    if (q_d.size() != 1) begin
      failures++; $display("FAIL rstmid_count got=%0d exp=1", q_d.size());
    end else begin
      checks++;
      if ({q_d[0], q_s[0], q_e[0], q_c[0]} !== {8'h44, 1'b1, 1'b1, 8'h01}) begin
        failures++; $display("FAIL rstmid_beat got d=%0h s=%b e=%b c=%0h exp d=44 s=1 e=1 c=1",
                             q_d[0], q_s[0], q_e[0], q_c[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_drop();
    test_backpressure();
    test_framing();
    test_saturation();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_master_chan_header_adapter.md
# lcd_master_chan_header_adapter

Parametrised Avalon-ST packet-to-channel adapter for the LCD master path, sitting between the byte-stream packet source and the channelised command/pixel sinks. The first beat of each packet is a header that carries the channel number. The adapter consumes that header, stores it, and sets `out_channel` to it on every payload beat of the packet. Packets addressed above `MAX_CHANNEL` are dropped and counted, and framing errors are flagged. All outputs pass through one registered pipeline stage.

## Interface
- `DATA_W`, default 8: payload width; the header beat uses the same width.
- `CHANNEL_W`, default 8: width of `out_channel`. Must satisfy CHANNEL_W ≤ DATA_W.
- `MAX_CHANNEL`, default 2**CHANNEL_W-1: highest legal channel. Packets whose header exceeds it are dropped.
- `CNT_W`, default 16: width of the dropped-packet counter.

Ports, listed as name, direction, width, meaning:
- `clk` in 1: sole clock. Everything is rising-edge.
- `reset` in 1: synchronous, active-high reset.
- `in_ready` out 1: sink ready.
- `in_valid` in 1: source beat valid.
- `in_data` in DATA_W: header or payload.
- `in_startofpacket` in 1: first beat of the packet, which is the header beat.
- `in_endofpacket` in 1: last beat of the packet.
- `out_ready` in 1: downstream ready.
- `out_valid` out 1: registered beat valid.
- `out_data` out DATA_W: payload.
- `out_startofpacket` out 1: first payload beat.
- `out_endofpacket` out 1: last payload beat.
- `out_channel` out CHANNEL_W: channel latched from the header.
- `err_framing` out 1: one-cycle pulse on a framing error.
- `drop_count` out CNT_W: count of dropped packets. Saturates at its maximum value.

## Operation
- State machine states: IDLE, PASS, DROP.
- IDLE:
  - `in_ready`=1.
  - Accepted beat with sop=1 is a header. ch = in_data[CHANNEL_W-1:0]. Upper in_data bits are ignored.
    - Header with eop=1 (empty packet): discard, pulse `err_framing`, stay IDLE.
    - Else if ch > MAX_CHANNEL: go to DROP and increment `drop_count`.
    - Else latch ch into `chan_q`, set `sop_pend`=1, go to PASS.
  - Accepted beat with sop=0: discard it, pulse `err_framing`, stay IDLE.
- PASS:
  - `in_ready` = !out_valid || out_ready.
  - Each accepted beat loads the output register:
    - data = in_data.
    - channel = `chan_q`.
    - out sop = `sop_pend`; `sop_pend` clears on that accept.
    - out eop = in_eop.
  - An accepted beat with eop=1 returns the FSM to IDLE.
  - An accepted beat with sop=1 in PASS is treated as a new header, evaluated exactly as in IDLE:
    - Pulse `err_framing`.
    - Nothing is written to the output register.
    - The previous output packet is left unterminated. Downstream handles this.
- DROP:
  - `in_ready`=1.
  - Beats are discarded.
  - An accepted beat with eop=1 returns the FSM to IDLE.
  - A beat with sop=1 in DROP: handle as in PASS (pulse `err_framing`, re-evaluate as header).
- Output register:
  - Holds its contents while out_valid=1 and out_ready=0.
  - Clears out_valid when the beat is taken and no new beat loads.
- `drop_count` increments by 1 per dropped header. No wrap.
- The header beat never reaches the output.

## Timing
- Reset values:
  - out_valid=0, out_data=0, out_startofpacket=0, out_endofpacket=0, out_channel=0.
  - err_framing=0, drop_count=0.
  - State IDLE; `chan_q`=0; `sop_pend`=0.
  - in_ready follows state, so it is 1 in the cycle after reset deasserts.
- Latency: a payload beat accepted at edge N is valid on the output from edge N, i.e. visible in cycle N+1. A header adds one input beat and no output beat.
- Throughput in PASS: 1 beat/cycle with out_ready held high. Back-to-back packets lose one cycle per packet, for the header.
- `in_ready` in PASS depends combinationally on `out_ready`. There is no skid buffer.
- `err_framing` asserts for the cycle after the offending accept.
- Reset asserted mid-packet:
  - The packet is abandoned.
  - The output register is cleared with no eop emitted.
  - The next beat must be a header.
- Simultaneous output take and input accept in PASS: the register reloads in the same edge with no bubble.

## Structure
- Package `lcd_master_st_pkg` holds:
  - The state enum (IDLE, PASS, DROP).
  - Localparam helpers for the default MAX_CHANNEL.
  - A payload-beat struct {data, sop, eop, channel}, shared with other LCD ST adapters.
- Sub-module `lcd_master_st_pipe_reg`: the parametrised one-entry ready/valid output register, reusable elsewhere.
- The FSM, header decode and counter stay in the top module.

## Test plan
- Basic pass: header 0x05, then payload A1, A2, A3 with eop on A3, out_ready=1. Expect:
  - 3 output beats with out_channel=5.
  - sop on A1 only, eop on A3.
  - A1 appears 1 cycle after its accept.
- Drop: MAX_CHANNEL=3, header 0x07, 4 payload beats. Expect:
  - No out_valid.
  - drop_count=1.
  - in_ready=1 throughout.
  - A following header 0x02 packet passes normally.
- Backpressure: out_ready toggles 1,0,0,1 during a 4-beat packet. Expect:
  - out_data held stable while out_ready=0.
  - in_ready=0 while the register is full and blocked.
  - No beat lost or duplicated.
- Framing errors: each of the following pulses `err_framing` once and forwards nothing for the bad beat.
  - Beat without sop in IDLE.
  - Header with eop.
  - sop in PASS. The new packet's header channel must be applied to its payload.
- Counter saturation: CNT_W=2, 5 dropped packets. Expect drop_count to stick at 3.
- Reset mid-packet: assert reset after the 2nd payload beat. Expect:
  - All outputs zero the next cycle.
  - The subsequent header 0x01 packet is delivered with out_channel=1 and sop set.
